// File: rtl/mimo_frame_loader.sv
// Detector input stage: assembles a word-serial H/y channel frame into flat buses,
// double-buffered so one frame is presented while the next one loads.
module mimo_frame_loader #(
    parameter int WL          = 16,
    parameter int FRAME_WORDS = 72
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WL-1:0]         in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [64*WL-1:0]      Hmatrix_o,
    output logic [8*WL-1:0]       Yarray_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err
);
    localparam int H_WORDS = 64;

    typedef enum logic [1:0] {LOAD_H, LOAD_Y, STALL} state_t;

    state_t                                  state;
    logic [1:0][FRAME_WORDS-1:0][WL-1:0]     bank;
    logic [1:0]                              full;
    logic [1:0]                              full_n;
    logic                                    wr_bank;
    logic                                    rd_bank;
    logic                                    wr_n;
    logic                                    rd_n;
    logic [6:0]                              idx;
    logic                                    accept;
    logic                                    last_idx;
    logic                                    bad;
    logic                                    done;
    logic                                    take;

    assign accept   = in_valid & in_ready;
    assign last_idx = (idx == 7'(FRAME_WORDS - 1));
    assign bad      = accept & (in_last != last_idx);
    assign done     = accept & in_last & last_idx;
    assign take     = out_valid & out_ready;
    assign rd_n     = rd_bank ^ take;
    assign wr_n     = wr_bank ^ done;

    // Release is applied before completion so a same-edge release keeps in_ready up.
    always_comb begin
        full_n = full;
        if (take) full_n[rd_bank] = 1'b0;
        if (done) full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_H;
            bank      <= '0;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            full      <= full_n;
            wr_bank   <= wr_n;
            rd_bank   <= rd_n;
            out_valid <= full_n[rd_n];
            frame_err <= bad;
            if (accept) bank[wr_bank][idx] <= in_data;

            case (state)
                LOAD_H, LOAD_Y: begin
                    if (accept) begin
                        if (bad) begin
                            state <= LOAD_H;
                            idx   <= '0;
                        end else if (done) begin
                            idx <= '0;
                            if (full_n[wr_n]) begin
                                state    <= STALL;
                                in_ready <= 1'b0;
                            end else begin
                                state <= LOAD_H;
                            end
                        end else begin
                            idx <= idx + 7'd1;
                            if (idx == 7'(H_WORDS - 1)) state <= LOAD_Y;
                        end
                    end
                end
                STALL: begin
                    // Uses the registered flag: resume one cycle after the release edge.
                    if (!full[wr_bank]) begin
                        state    <= LOAD_H;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= LOAD_H;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // The presented bank is never written while full, so these stay stable under backpressure.
    assign Hmatrix_o = bank[rd_bank][H_WORDS-1:0];
    assign Yarray_o  = bank[rd_bank][FRAME_WORDS-1:H_WORDS];

endmodule

// File: doc/mimo_frame_loader.md
# mimo_frame_loader

Input stage of the detector pipeline: collects one channel frame (8x8 real-valued H matrix plus 8-element y vector) from a word-serial valid/ready stream. It assembles the frame into the flat packed buses consumed by the first decomposition stage, which computes the initial column norms and column order. Frames are double-buffered, so one frame is presented downstream while the next one loads, and malformed frames are detected and discarded.

## Interface

**Parameters**
- WL, default 16: word length of one H/y element; instantiated with `WL.
- FRAME_WORDS, default 72: words per frame, 64 H followed by 8 y; fixed, not meant to be overridden.

**Ports**
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WL  stream element, two's complement.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks last word of a frame; qualified by in_valid.
- in_ready  out  1  loader accepts a word this cycle.
- Hmatrix_o  out  64*WL  element (r,c) at bits [WL*(8r+c)+WL-1 : WL*(8r+c)].
- Yarray_o  out  8*WL  element r at bits [WL*r+WL-1 : WL*r].
- out_valid  out  1  Hmatrix_o/Yarray_o hold a complete frame.
- out_ready  in  1  downstream takes the presented frame.
- frame_err  out  1  one-cycle pulse: malformed frame discarded.

## Operation

- **Word acceptance:** a word is accepted on a rising edge with in_valid & in_ready.
- **Word order:** word index k = 0..63 is written to H(r = k/8, c = k%8), row-major. k = 64..71 is written to y(k-64).
- **Buffering:** two banks, each holding 72 x WL bits plus a full flag.
  - wr_bank is the bank being filled; rd_bank is the bank being presented.
  - The banks alternate, starting from bank 0 for both pointers.
- **Write FSM states:** LOAD_H, LOAD_Y, STALL. The word counter idx is 7 bits.
  - LOAD_H: accepting words 0..63. Accepting word 63 moves to LOAD_Y.
  - LOAD_Y: accepting words 64..71.
  - Accepting word 71 with in_last=1 sets full[wr_bank] and toggles wr_bank. idx returns to 0.
  - Next state is LOAD_H if the new wr_bank is empty, otherwise STALL.
  - STALL: in_ready=0. Moves to LOAD_H on the cycle after full[wr_bank] clears.
- **Error handling:**
  - Case 1: in_last=1 on an accepted word with idx != 71.
  - Case 2: in_last=0 on an accepted word with idx == 71.
  - Either case: pulse frame_err, set idx to 0, return to LOAD_H, leave bank full flags unchanged. The partial bank contents are don't-care and are overwritten by the next frame.
- **Read side:**
  - out_valid = full[rd_bank], registered.
  - On out_valid & out_ready: clear full[rd_bank] and toggle rd_bank.
  - Hmatrix_o and Yarray_o are muxed from rd_bank. They are held stable while out_valid & ~out_ready.
- **Data handling:** no arithmetic is performed; words are stored bit-exact.

## Timing

- **Reset values:** in_ready=1, out_valid=0, frame_err=0, Hmatrix_o=0, Yarray_o=0. Both banks are cleared, full flags = 0, idx=0, state LOAD_H.
  - Reset mid-frame discards all buffered and partial data.
- **Latency:** the final word is accepted at edge t; out_valid=1 from edge t, i.e. visible in the cycle after that word's handshake, provided the rd side is empty.
- **Throughput:** with out_ready held at 1, in_ready stays 1 continuously, giving 1 word/cycle and 72 cycles per frame.
- **Bank release and completion in the same edge:** legal.
  - The release applies first when computing next state, so in_ready does not drop.
  - out_valid stays 1 if the other bank is already full; the new frame appears at the next edge.
- **Both banks full:** in_ready=0 from the edge the second frame completes, until the edge after the first out_ready handshake.
- **Presented-frame integrity:** the presented frame is never overwritten. A write to rd_bank while its full flag is set is impossible by construction.
- **Sampling without valid:** in_last and in_data are ignored when in_valid=0 or in_ready=0.

## Test plan

- **Single frame:** reset, then stream words with in_data = k+1 for k=0..71, in_last on k=71, out_ready=0.
  - Required: out_valid=1 the cycle after the last word.
  - Required: Hmatrix_o element (2,5) = 22; Yarray_o element 7 = 72.
- **Back-to-back throughput:** three frames streamed back to back with out_ready=1.
  - Required: in_ready never drops.
  - Required: out_valid pulses once per frame, 72 cycles apart, and the data matches each frame.
- **Backpressure:** two frames with out_ready=0.
  - Required: in_ready drops right after the second frame completes.
  - Required: the first frame stays stable on the outputs.
  - On out_ready=1 for one cycle, the second frame is presented and in_ready returns to 1 one cycle later.
- **Malformed frames:**
  - in_last on word 40 -> frame_err pulses once, out_valid stays 0, and the next clean frame loads correctly.
  - Word 71 without in_last -> frame_err pulses, and the frame is discarded.
- **Gaps and reset mid-frame:**
  - Random in_valid gaps (about 50% duty) -> identical output data to the gap-free case.
  - Assert rst at word 30 -> all outputs return to their reset values, and a following full frame is presented correctly.
